// File: rtl/pwm_capture.sv
// PWM capture: synchronises an asynchronous PWM pad input and measures the
// period and high time between successive rising edges, with timeout detection.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic             io_oeb_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             sample_valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   p_q;
    logic                   s_w;
    logic                   rise_w;
    logic                   fall_w;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] hl_q,      hl_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] high_q,    high_d;
    logic             valid_q,   valid_d;
    logic             timeout_q, timeout_d;
    logic             stuck_q,   stuck_d;
    logic [CNT_W-1:0] cnt_inc_w;

    assign s_w       = sync_q[SYNC_STAGES-1];
    assign rise_w    = s_w & ~p_q;
    assign fall_w    = ~s_w & p_q;
    assign cnt_inc_w = cnt_q + CNT_ONE;

    // Pad input synchroniser plus the one-cycle delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            p_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            p_q    <= s_w;
        end
    end

    // Measurement FSM next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hl_d      = hl_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        stuck_d   = stuck_q;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_w) begin
                        state_d   = ST_HIGH;
                        cnt_d     = CNT_ONE;
                        timeout_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                // Saturation wins over a fall: a legal high time is always shorter than the period
                ST_HIGH: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = CNT_MAX;
                        timeout_d = 1'b1;
                        stuck_d   = s_w;
                    end else if (fall_w) begin
                        hl_d    = cnt_q;
                        state_d = ST_LOW;
                        cnt_d   = cnt_inc_w;
                    end else begin
                        cnt_d = cnt_inc_w;
                    end
                end
                // A rise wins here so a period of exactly CNT_MAX-1 is still reported
                ST_LOW: begin
                    if (rise_w) begin
                        period_d = cnt_q;
                        high_d   = hl_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                        state_d  = ST_HIGH;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = CNT_MAX;
                        timeout_d = 1'b1;
                        stuck_d   = s_w;
                    end else begin
                        cnt_d = cnt_inc_w;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            hl_q      <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hl_q      <= hl_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            stuck_q   <= stuck_d;
        end
    end

    assign io_oeb_in    = 1'b1;
    assign period_cnt   = period_q;
    assign high_cnt     = high_q;
    assign sample_valid = valid_q;
    assign timeout      = timeout_q;
    assign stuck_level  = stuck_q;

endmodule
